universal_shift_register: RTL
=============================

// Module: universal_shift_register
// PURPOSE
//  Parametrised multi-mode shift register. Supports parallel load, plus
//  multi-position shifts run one bit per clock under a START/BUSY/DONE handshake.
//  Shift modes: logical, arithmetic, rotate and serial-fill, in either direction.
//  Sits between datapath registers and serial/bit-manipulation logic.
// PARAMETERS
//  WIDTH  8  data register width in bits (>=2)
//  AMT_W  3  width of shift-amount input; max shift per op = 2**AMT_W-1
// PORTS
//  CLK       in   1      rising-edge clock
//  RST       in   1      synchronous reset, active-high
//  LOAD      in   1      parallel load request (O<=D), honoured in IDLE only
//  D         in   WIDTH  parallel load data
//  START     in   1      begin shift op, honoured in IDLE only
//  MODE      in   2      00 logical, 01 arithmetic, 10 rotate, 11 serial-fill
//  LR_Shift  in   1      0 = shift left (toward MSB), 1 = shift right (toward LSB)
//  AMT       in   AMT_W  number of positions to shift
//  SIN       in   1      serial input bit, used in MODE 11
//  O         out  WIDTH  register contents
//  SOUT      out  1      most recently ejected bit
//  BUSY      out  1      high while a shift op is in progress
//  DONE      out  1      one-cycle pulse on completion of a shift op
// BEHAVIOUR
//  - Reset (at CLK edge with RST=1): O=0, SOUT=0, BUSY=0, DONE=0, state IDLE, count=0.
//    RST overrides every other input, including mid-operation; an aborted op never raises DONE.
//  - FSM states IDLE, SHIFT. BUSY=1 exactly when state==SHIFT. DONE defaults to 0 each cycle.
//  - IDLE, LOAD=1: O<=D; SOUT unchanged. Priority: LOAD over START; a simultaneous START is dropped.
//  - IDLE, START=1, LOAD=0, AMT!=0:
//    MODE, LR_Shift and AMT are latched; count<=AMT; next state SHIFT; O not shifted on this edge.
//  - IDLE, START=1, AMT==0: stay IDLE, DONE=1 next cycle, O/SOUT unchanged.
//  - SHIFT, each edge: one-position shift using the latched MODE and direction.
//    count decrements by 1. On the edge where count==1: shift, go to IDLE, BUSY<=0, DONE<=1.
//  - Latency: AMT shift edges after the START edge. BUSY is high for AMT cycles, then DONE pulses.
//  - LOAD/START while BUSY are ignored; not queued. Changes to MODE, LR_Shift or AMT
//    while BUSY have no effect. SIN is sampled live on every shift edge.
//  - Left shift: O<={O[WIDTH-2:0],fill}; SOUT<=O[WIDTH-1].
//  - Right shift: O<={fill,O[WIDTH-1:1]}; SOUT<=O[0].
//  - Fill bit by mode:
//    logical: 0.
//    arithmetic: right fills O[WIDTH-1] (sign kept); left fills 0.
//    rotate: the ejected bit.
//    serial-fill: SIN.
//  - No overflow/wrap of count: AMT range is fully covered by AMT_W bits.
// TESTING (WIDTH=8, AMT_W=3)
//  1. RST=1 for 2 cycles with random inputs -> O=8'h00, SOUT=0, BUSY=0, DONE=0.
//  2. LOAD D=8'h81; START MODE=10 LR=0 AMT=3
//     -> BUSY high 3 cycles, O=8'h0C, SOUT=0, DONE single pulse.
//  3. LOAD 8'h90; START MODE=01 LR=1 AMT=2 -> O=8'hE4, SOUT=0, DONE pulse.
//  4. From O=0, MODE=11 LR=1 SIN=1 AMT=7 -> O=8'hFE.
//     Then MODE=00 LR=0 AMT=1 -> O=8'hFC, SOUT=1.
//  5. START/LOAD pulsed while BUSY -> ignored, result unchanged.
//     LOAD+START together in IDLE -> load only.
//     AMT=0 -> DONE next cycle, BUSY stays 0.
//  6. RST after 2 of 5 shifts -> next edge O=0, BUSY=0.
//     No DONE afterwards; a new op then completes normally.

Source files
------------

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Purpose:
//   Parametrised multi-mode shift register. A parallel load writes D into the
//   register. A START request runs a multi-position shift, one bit per clock,
//   under a START/BUSY/DONE handshake. Shift modes are logical, arithmetic,
//   rotate and serial-fill, and each can shift left or right.
//
// Parameters:
//   WIDTH  data register width in bits (>= 2)
//   AMT_W  width of the shift-amount input; max shift per op = 2**AMT_W-1
//
// Ports:
//   CLK       in   1      rising-edge clock
//   RST       in   1      synchronous reset, active-high
//   LOAD      in   1      parallel load request (O <= D), honoured in IDLE only
//   D         in   WIDTH  parallel load data
//   START     in   1      begin a shift op, honoured in IDLE only
//   MODE      in   2      00 logical, 01 arithmetic, 10 rotate, 11 serial-fill
//   LR_Shift  in   1      0 = shift left (toward MSB), 1 = shift right
//   AMT       in   AMT_W  number of positions to shift
//   SIN       in   1      serial input bit, used in serial-fill mode
//   O         out  WIDTH  register contents
//   SOUT      out  1      most recently ejected bit
//   BUSY      out  1      high while a shift op is in progress
//   DONE      out  1      one-cycle pulse on completion of a shift op
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic             LR_Shift,
  input  logic [AMT_W-1:0] AMT,
  input  logic             SIN,
  output logic [WIDTH-1:0] O,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0]       MODE_LOG = 2'b00;
  localparam logic [1:0]       MODE_ARI = 2'b01;
  localparam logic [1:0]       MODE_ROT = 2'b10;
  localparam logic [1:0]       MODE_SER = 2'b11;
  localparam logic [AMT_W-1:0] CNT_ZERO = AMT_W'(0);
  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q,  mode_d;
  logic             right_q, right_d;
  logic [WIDTH-1:0] o_q,     o_d;
  logic             sout_q,  sout_d;
  logic             done_q,  done_d;
  logic [WIDTH:0]   shift_s;

  // One-position shift. Returns {ejected_bit, shifted_value}.
  function automatic logic [WIDTH:0] shift_one(
    input logic [WIDTH-1:0] val,
    input logic [1:0]       mode,
    input logic             right,
    input logic             sin
  );
    logic ejected;
    logic fill;
    if (right) begin
      ejected = val[0];
    end else begin
      ejected = val[WIDTH-1];
    end
    case (mode)
      MODE_LOG: fill = 1'b0;
      MODE_ARI: begin
        // Sign is only preserved on right shifts; left arithmetic fills zero.
        if (right) begin
          fill = val[WIDTH-1];
        end else begin
          fill = 1'b0;
        end
      end
      MODE_ROT: fill = ejected;
      MODE_SER: fill = sin;
      default:  fill = 1'b0;
    endcase
    if (right) begin
      shift_one = {ejected, fill, val[WIDTH-1:1]};
    end else begin
      shift_one = {ejected, val[WIDTH-2:0], fill};
    end
  endfunction

  // Single-step shift of the current register using the latched op settings.
  always_comb begin
    shift_s = shift_one(o_q, mode_q, right_q, SIN);
  end

  // Next-state and datapath logic for the IDLE/SHIFT controller.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    right_d = right_q;
    o_d     = o_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          // LOAD wins over a simultaneous START; the START is dropped.
          o_d = D;
        end else if (START) begin
          if (AMT != CNT_ZERO) begin
            mode_d  = MODE;
            right_d = LR_Shift;
            count_d = AMT;
            state_d = S_SHIFT;
          end else begin
            // Zero-length op completes immediately with no data change.
            done_d = 1'b0 | 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        o_d     = shift_s[WIDTH-1:0];
        sout_d  = shift_s[WIDTH];
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= CNT_ZERO;
      mode_q  <= MODE_LOG;
      right_q <= 1'b0;
      o_q     <= {WIDTH{1'b0}};
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      right_q <= right_d;
      o_q     <= o_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign O    = o_q;
  assign SOUT = sout_q;
  assign BUSY = (state_q == S_SHIFT);
  assign DONE = done_q;

endmodule
